// File: rtl/run_controller_pkg.sv
// Shared types for the run sequencer: FSM states and the run outcome reported to the host.
package run_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } run_state_e;

    typedef enum logic [2:0] {
        ST_NONE,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT,
        ST_HANG
    } run_status_e;

endpackage

// File: rtl/run_controller_if.sv
// Core-facing bundle of the run sequencer: start request, PC/store snoop inputs, run results out.
interface run_controller_if #(
    parameter int unsigned CNT_W = 32
);
    import run_controller_pkg::*;

    logic              start_i;
    logic [31:0]       pc_i;
    logic              st_en_i;
    logic [31:0]       st_addr_i;
    logic [31:0]       st_data_i;
    logic              core_rst_no;
    logic              running_o;
    logic              done_o;
    run_status_e       status_o;
    logic [31:0]       exit_code_o;
    logic [CNT_W-1:0]  cycles_o;

    modport master (
        output start_i, pc_i, st_en_i, st_addr_i, st_data_i,
        input  core_rst_no, running_o, done_o, status_o, exit_code_o, cycles_o
    );

    modport slave (
        input  start_i, pc_i, st_en_i, st_addr_i, st_data_i,
        output core_rst_no, running_o, done_o, status_o, exit_code_o, cycles_o
    );

endinterface

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable); max_o flags all-ones.
// One-cycle update latency; no backpressure, the counter simply stops at all-ones.
module run_controller_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o,
    output logic         max_o
);

    logic [W-1:0] q_q, q_d;

    assign max_o = &q_q;
    assign q_o   = q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i && !max_o) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run sequencer: holds the core in reset, runs it, ends the run on tohost store, watchdog or PC hang.
// All outputs registered (status one cycle after the deciding sample); start_i only acts in IDLE/DONE.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 200,
    parameter int unsigned HANG_CYCLES    = 16,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_7000,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    run_controller_if.slave bus
);

    run_state_e       state_q, state_d;
    run_status_e      status_q, status_d;
    logic [31:0]      exit_q, exit_d;
    logic [31:0]      pc_prev_q;
    logic             core_rst_n_q, running_q, done_q;
    logic [CNT_W-1:0] rst_cnt, cyc_cnt, stall_cnt;
    logic             rst_max_unused, cyc_max_unused, stall_max_unused;
    logic             start_run, first_run, pc_same;
    logic             tohost_hit, timeout_hit, hang_hit, reset_last;

    assign start_run   = ((state_q == S_IDLE) && (AUTO_START || bus.start_i)) ||
                         ((state_q == S_DONE) && bus.start_i);
    // The cycle counter is still zero during the first RUN cycle, so no PC snapshot exists yet.
    assign first_run   = (cyc_cnt == '0);
    assign pc_same     = (state_q == S_RUN) && !first_run && (bus.pc_i == pc_prev_q);
    assign tohost_hit  = bus.st_en_i && (bus.st_addr_i == TOHOST_ADDR) && bus.st_data_i[0];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cyc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign hang_hit    = (HANG_CYCLES != 0) && pc_same && (stall_cnt == CNT_W'(HANG_CYCLES - 1));
    assign reset_last  = (rst_cnt == CNT_W'(RST_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        exit_d   = exit_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_run) state_d = S_RESET;
            end
            S_RESET: begin
                if (reset_last) state_d = S_RUN;
            end
            S_RUN: begin
                if (tohost_hit) begin
                    state_d = S_DONE;
                    if (bus.st_data_i == 32'd1) begin
                        status_d = ST_PASS;
                        exit_d   = '0;
                    end else begin
                        status_d = ST_FAIL;
                        exit_d   = bus.st_data_i >> 1;
                    end
                end else if (timeout_hit) begin
                    state_d  = S_DONE;
                    status_d = ST_TIMEOUT;
                end else if (hang_hit) begin
                    state_d  = S_DONE;
                    status_d = ST_HANG;
                end
            end
            S_DONE: begin
                if (start_run) begin
                    state_d  = S_RESET;
                    status_d = ST_NONE;
                    exit_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            status_q     <= ST_NONE;
            exit_q       <= '0;
            pc_prev_q    <= '0;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            exit_q       <= exit_d;
            if (state_q == S_RUN) pc_prev_q <= bus.pc_i;
            core_rst_n_q <= (state_d == S_RUN);
            running_q    <= (state_d == S_RUN);
            done_q       <= (state_d == S_DONE);
        end
    end

    run_controller_sat_counter #(.W(CNT_W)) u_rst_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q != S_RESET),
        .en_i  (state_q == S_RESET),
        .q_o   (rst_cnt),
        .max_o (rst_max_unused)
    );

    run_controller_sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_run),
        .en_i  (state_q == S_RUN),
        .q_o   (cyc_cnt),
        .max_o (cyc_max_unused)
    );

    run_controller_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (!pc_same),
        .en_i  (pc_same),
        .q_o   (stall_cnt),
        .max_o (stall_max_unused)
    );

    assign bus.core_rst_no = core_rst_n_q;
    assign bus.running_o   = running_q;
    assign bus.done_o      = done_q;
    assign bus.status_o    = status_q;
    assign bus.exit_code_o = exit_q;
    assign bus.cycles_o    = cyc_cnt;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: three instances (defaults, hang watchdog off, manual start) share one stimulus.
module tb_run_controller;
    import run_controller_pkg::*;

    localparam int N       = 3;
    localparam int P_IDLE  = 0;
    localparam int P_RESET = 1;
    localparam int P_RUN   = 2;
    localparam int P_DONE  = 3;
    localparam int RSTC    = 3;
    localparam int TMO     = 200;
    localparam logic [31:0] TOHOST = 32'h0000_7000;

    typedef struct packed {
        logic        crn;
        logic        run;
        logic        dn;
        run_status_e st;
        logic [31:0] ex;
        logic [31:0] cy;
    } obs_t;

    typedef struct {
        int          phase;
        int          rleft;
        bit          have_pc;
        logic [31:0] last_pc;
        int          same;
        logic [31:0] cycles;
        run_status_e status;
        logic [31:0] exit;
    } mdl_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] pc      = '0;
    logic        st_en   = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    int          n_asrt  = 0;
    int          n_fail  = 0;
    mdl_t        m [N];

    always #5 clk = ~clk;

    run_controller_if #(.CNT_W(32)) bus_a ();
    run_controller_if #(.CNT_W(32)) bus_h ();
    run_controller_if #(.CNT_W(32)) bus_s ();

    assign bus_a.start_i = start;  assign bus_h.start_i = start;  assign bus_s.start_i = start;
    assign bus_a.pc_i = pc;        assign bus_h.pc_i = pc;        assign bus_s.pc_i = pc;
    assign bus_a.st_en_i = st_en;  assign bus_h.st_en_i = st_en;  assign bus_s.st_en_i = st_en;
    assign bus_a.st_addr_i = st_addr; assign bus_h.st_addr_i = st_addr; assign bus_s.st_addr_i = st_addr;
    assign bus_a.st_data_i = st_data; assign bus_h.st_data_i = st_data; assign bus_s.st_data_i = st_data;

    run_controller u_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave));
    run_controller #(.HANG_CYCLES(0)) u_h (.clk_i(clk), .rst_i(rst), .bus(bus_h.slave));
    run_controller #(.AUTO_START(1'b0)) u_s (.clk_i(clk), .rst_i(rst), .bus(bus_s.slave));

    function automatic bit auto_of(input int k);
        return k != 2;
    endfunction

    function automatic int hang_of(input int k);
        return (k == 1) ? 0 : 16;
    endfunction

    function automatic mdl_t mdl_idle();
        mdl_t r;
        r.phase = P_IDLE; r.rleft = 0; r.have_pc = 1'b0; r.last_pc = '0; r.same = 0;
        r.cycles = '0; r.status = ST_NONE; r.exit = '0;
        return r;
    endfunction

    function automatic mdl_t mdl_begin();
        mdl_t r = mdl_idle();
        r.phase = P_RESET;
        r.rleft = RSTC;
        return r;
    endfunction

    // Reference behaviour of one instance across one clock edge, from the inputs present at that edge.
    function automatic mdl_t next_m(input mdl_t c, input int k);
        mdl_t n = c;
        case (c.phase)
            P_IDLE: if (auto_of(k) || start) n = mdl_begin();
            P_RESET: begin
                n.rleft = c.rleft - 1;
                if (n.rleft == 0) begin
                    n.phase   = P_RUN;
                    n.have_pc = 1'b0;
                end
            end
            P_RUN: begin
                n.cycles  = (c.cycles == 32'hFFFF_FFFF) ? c.cycles : c.cycles + 32'd1;
                n.same    = (c.have_pc && pc == c.last_pc) ? c.same + 1 : 0;
                n.have_pc = 1'b1;
                n.last_pc = pc;
                if (st_en && st_addr == TOHOST && st_data[0]) begin
                    n.phase  = P_DONE;
                    n.status = (st_data == 32'd1) ? ST_PASS : ST_FAIL;
                    n.exit   = (st_data == 32'd1) ? 32'd0 : (st_data >> 1);
                end else if (TMO != 0 && n.cycles == 32'(TMO)) begin
                    n.phase  = P_DONE;
                    n.status = ST_TIMEOUT;
                end else if (hang_of(k) != 0 && n.same == hang_of(k)) begin
                    n.phase  = P_DONE;
                    n.status = ST_HANG;
                end
            end
            default: if (start) n = mdl_begin();
        endcase
        return n;
    endfunction

    function automatic obs_t sample(input int k);
        obs_t o;
        case (k)
            0: o = '{bus_a.core_rst_no, bus_a.running_o, bus_a.done_o, bus_a.status_o, bus_a.exit_code_o, bus_a.cycles_o};
            1: o = '{bus_h.core_rst_no, bus_h.running_o, bus_h.done_o, bus_h.status_o, bus_h.exit_code_o, bus_h.cycles_o};
            default: o = '{bus_s.core_rst_no, bus_s.running_o, bus_s.done_o, bus_s.status_o, bus_s.exit_code_o, bus_s.cycles_o};
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_asrt++;
        assert (obs_v === exp_v) else begin
            n_fail++;
            $error("FAIL %s[dut%0d] t=%0t observed=%h expected=%h", tag, k, $time, obs_v, exp_v);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            obs_t o = sample(k);
            chk("core_rst_no", k, 32'(o.crn), 32'(m[k].phase == P_RUN));
            chk("running_o",   k, 32'(o.run), 32'(m[k].phase == P_RUN));
            chk("done_o",      k, 32'(o.dn),  32'(m[k].phase == P_DONE));
            chk("status_o",    k, 32'(o.st),  32'(m[k].status));
            chk("exit_code_o", k, o.ex, m[k].exit);
            chk("cycles_o",    k, o.cy, m[k].cycles);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < N; k++) m[k] = next_m(m[k], k);
        @(negedge clk);
        check_all();
    endtask

    // mode 0: PC advances; mode 1: PC stuck at 0x40; otherwise PC wanders over a few values.
    task automatic noise(input int mode);
        start = 1'b0;
        case (mode)
            0: pc = pc + 32'd4;
            1: pc = 32'h40;
            default: if ($urandom_range(0, 1) == 0) pc = 32'($urandom_range(0, 3)) << 2;
        endcase
        st_en   = 1'($urandom_range(0, 1));
        st_addr = 32'($urandom_range(0, 32'h6FFC));
        st_data = $urandom;
    endtask

    task automatic drive_store(input logic [31:0] data);
        start   = 1'b0;
        pc      = pc + 32'd4;
        st_en   = 1'b1;
        st_addr = TOHOST;
        st_data = data;
    endtask

    // Advance until instance 0 is in its RUN cycle number cyc (the next edge ends that cycle).
    task automatic run_to(input int cyc, input int mode);
        int b = 0;
        while (!(m[0].phase == P_RUN && m[0].cycles == 32'(cyc - 1)) && b < 1000) begin
            noise(mode);
            step();
            b++;
        end
        chk("run_to_budget", 0, 32'(b < 1000), 32'd1);
    endtask

    task automatic wait_done(input int k, input int mode);
        int b = 0;
        while (m[k].phase != P_DONE && b < 400) begin
            noise(mode);
            step();
            b++;
        end
        chk("done_budget", k, 32'(b < 400), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < N; k++) m[k] = mdl_idle();
        #1 rst = 1'b1;
        @(negedge clk);
        check_all();
        chk("rst_cycles", 0, bus_a.cycles_o, 32'd0);
        chk("rst_core_rst_no", 0, 32'(bus_a.core_rst_no), 32'd0);
        rst = 1'b0;
        noise(0);
        step();
        chk("autostart_reset", 0, 32'(bus_a.core_rst_no), 32'd0);

        // Pass at RUN cycle 40
        run_to(40, 0);
        drive_store(32'd1);
        step();
        chk("pass_status", 0, 32'(bus_a.status_o), 32'(ST_PASS));
        chk("pass_exit", 0, bus_a.exit_code_o, 32'd0);
        chk("pass_cycles", 0, bus_a.cycles_o, 32'd40);
        chk("pass_done", 0, 32'(bus_a.done_o), 32'd1);
        chk("s_no_autostart", 2, 32'(bus_s.running_o), 32'd0);
        repeat (3) begin noise(0); step(); end
        chk("pass_held", 0, bus_a.cycles_o, 32'd40);

        // Restart from DONE; manual-start instance begins here, reset low exactly 3 cycles
        noise(0); start = 1'b1;
        step();
        chk("restart_cleared", 0, 32'(bus_a.status_o), 32'(ST_NONE));
        chk("s_reset_low0", 2, 32'(bus_s.core_rst_no), 32'd0);
        noise(0); step();
        chk("s_reset_low1", 2, 32'(bus_s.core_rst_no), 32'd0);
        noise(0); step();
        chk("s_reset_low2", 2, 32'(bus_s.core_rst_no), 32'd0);
        noise(0); step();
        chk("s_reset_release", 2, 32'(bus_s.core_rst_no), 32'd1);

        run_to(5, 0);
        drive_store(32'd6);
        step();
        chk("even_store_ignored", 0, 32'(bus_a.running_o), 32'd1);
        run_to(10, 0);
        drive_store(32'd7);
        step();
        chk("fail_status", 0, 32'(bus_a.status_o), 32'(ST_FAIL));
        chk("fail_exit", 0, bus_a.exit_code_o, 32'd3);

        // Watchdog
        noise(0); start = 1'b1;
        step();
        run_to(200, 0);
        chk("timeout_last_run", 0, 32'(bus_a.core_rst_no), 32'd1);
        noise(0);
        step();
        chk("timeout_status", 0, 32'(bus_a.status_o), 32'(ST_TIMEOUT));
        chk("timeout_cycles", 0, bus_a.cycles_o, 32'd200);
        chk("timeout_core_rst", 0, 32'(bus_a.core_rst_no), 32'd0);

        // PC stuck at 0x40
        noise(1); start = 1'b1;
        step();
        wait_done(0, 1);
        chk("hang_status", 0, 32'(bus_a.status_o), 32'(ST_HANG));
        chk("hang_cycles", 0, bus_a.cycles_o, 32'd17);
        wait_done(1, 1);
        chk("nohang_status", 1, 32'(bus_h.status_o), 32'(ST_TIMEOUT));
        chk("nohang_cycles", 1, bus_h.cycles_o, 32'd200);

        // Tohost on the cycle the watchdog expires
        noise(0); start = 1'b1;
        step();
        run_to(200, 0);
        drive_store(32'd1);
        step();
        chk("tie_status", 0, 32'(bus_a.status_o), 32'(ST_PASS));
        chk("tie_cycles", 0, bus_a.cycles_o, 32'd200);

        // Asynchronous reset between edges while running
        noise(0); start = 1'b1;
        step();
        repeat (17) begin noise(0); step(); end
        chk("pre_async_running", 0, 32'(bus_a.running_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) m[k] = mdl_idle();
        check_all();
        chk("async_core_rst", 0, 32'(bus_a.core_rst_no), 32'd0);
        chk("async_cycles", 0, bus_a.cycles_o, 32'd0);
        #1 rst = 1'b0;

        // Random traffic with occasional restarts and tohost stores
        repeat (600) begin
            noise(2);
            if ($urandom_range(0, 29) == 0) start = 1'b1;
            if ($urandom_range(0, 39) == 0) begin
                st_en   = 1'b1;
                st_addr = TOHOST;
                st_data = 32'($urandom_range(0, 7));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
